// File: rtl/mem_req_arb_pkg.sv
// mem_req_arb_pkg
// Shared types for the memory-side request arbiter:
//   - arb_state_t : bus-master FSM states (IDLE / ADDR / DATA)
//   - owner_t     : which side issued the in-flight request
//   - mem_req_t   : latched request fields driven onto the bus
// The request struct is sized by ARB_ADDR_W / ARB_DATA_W; the top-level
// ADDR_W / DATA_W parameters default to these and must stay equal to them.
package mem_req_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] paddr;
        logic                  uncached;
        logic                  wr;
        logic [ARB_STRB_W-1:0] wstrb;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_arb_sel.sv
// mem_req_arb_sel
// Two-way combinational grant between the instruction and data sides.
// Build option MEM_ARB_RR_EN:
//   undefined : fixed priority, data side wins on contention.
//   defined   : round-robin; last_grant (reset = inst) remembers the most
//               recent accepted grant and the other side wins on contention.
// Ports:
//   clk, reset, accept : only present with MEM_ARB_RR_EN (accept = handshake
//                        happened this cycle, updates last_grant)
//   inst_valid, data_valid : request valids
//   grant_inst, grant_data : one-hot-or-zero grant
module mem_req_arb_sel
    import mem_req_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic accept,
`endif
    input  logic inst_valid,
    input  logic data_valid,
    output logic grant_inst,
    output logic grant_data
);

    logic prefer_data;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= OWNER_INST;
        end else if (accept) begin
            last_grant <= grant_data ? OWNER_DATA : OWNER_INST;
        end
    end

    // Favour whichever side did not win last time.
    assign prefer_data = (last_grant == OWNER_INST);
`else
    assign prefer_data = 1'b1;
`endif

    assign grant_data = data_valid && (prefer_data || !inst_valid);
    assign grant_inst = inst_valid && !grant_data;

endmodule

// File: rtl/mem_req_arb.sv
// mem_req_arb
// Memory-side end of the translated-address path. Arbitrates the inst and
// data physical-address requests onto a single-outstanding SRAM-like bus
// (req / addr_ok / data_ok) and routes the completion back to the issuer.
// Build option MEM_ARB_RR_EN selects round-robin arbitration (default: data
// side has fixed priority).
// Ports:
//   clk, reset           : clock, async active-high reset
//   inst_req_*           : fetch request (valid/ready/paddr/uncached)
//   inst_resp_*          : one-cycle fetch data return
//   data_req_*           : load/store request (valid/ready/paddr/uncached/
//                          wr/wstrb/wdata)
//   data_resp_*          : one-cycle load data / store completion (rdata 0)
//   bus_req..bus_uncached: bus master request, all zero while bus_req is 0
//   bus_addr_ok/data_ok  : bus handshakes; bus_rdata read data
module mem_req_arb
    import mem_req_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    input  logic [ADDR_W-1:0]   inst_req_paddr,
    input  logic                inst_req_uncached,
    output logic                inst_resp_valid,
    output logic [DATA_W-1:0]   inst_resp_rdata,

    input  logic                data_req_valid,
    output logic                data_req_ready,
    input  logic [ADDR_W-1:0]   data_req_paddr,
    input  logic                data_req_uncached,
    input  logic                data_req_wr,
    input  logic [DATA_W/8-1:0] data_req_wstrb,
    input  logic [DATA_W-1:0]   data_req_wdata,
    output logic                data_resp_valid,
    output logic [DATA_W-1:0]   data_resp_rdata,

    output logic                bus_req,
    output logic                bus_wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic                bus_uncached,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    arb_state_t  state, state_nxt;
    mem_req_t    req_q;
    owner_t      owner_q;

    logic        grant_inst, grant_data;
    logic        accept_inst, accept_data;
    logic        complete;
    logic [DATA_W-1:0] cap_data;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    mem_req_arb_sel u_sel (
`ifdef MEM_ARB_RR_EN
        .clk        (clk),
        .reset      (reset),
        .accept     (accept_inst || accept_data),
`endif
        .inst_valid (inst_req_valid),
        .data_valid (data_req_valid),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // Ready is gated by reset so nothing looks accepted while it is held.
    assign inst_req_ready = !reset && (state == ST_IDLE) && grant_inst;
    assign data_req_ready = !reset && (state == ST_IDLE) && grant_data;

    assign accept_inst = inst_req_valid && inst_req_ready;
    assign accept_data = data_req_valid && data_req_ready;

    // Completion: data_ok in DATA, or addr_ok+data_ok together in ADDR.
    // data_ok arriving in IDLE, or in ADDR without addr_ok, is ignored.
    assign complete = ((state == ST_ADDR) && bus_addr_ok && bus_data_ok) ||
                      ((state == ST_DATA) && bus_data_ok);

    assign cap_data = req_q.wr ? '0 : bus_rdata;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_inst || accept_data) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (bus_addr_ok) state_nxt = bus_data_ok ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bus_data_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Request latch and registered response
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q           <= '0;
            owner_q         <= OWNER_INST;
            inst_resp_valid <= 1'b0;
            data_resp_valid <= 1'b0;
            inst_resp_rdata <= '0;
            data_resp_rdata <= '0;
        end else begin
            if (accept_data) begin
                req_q.paddr    <= data_req_paddr;
                req_q.uncached <= data_req_uncached;
                req_q.wr       <= data_req_wr;
                req_q.wstrb    <= data_req_wstrb;
                req_q.wdata    <= data_req_wdata;
                owner_q        <= OWNER_DATA;
            end else if (accept_inst) begin
                req_q.paddr    <= inst_req_paddr;
                req_q.uncached <= inst_req_uncached;
                req_q.wr       <= 1'b0;
                req_q.wstrb    <= '0;
                req_q.wdata    <= '0;
                owner_q        <= OWNER_INST;
            end

            inst_resp_valid <= complete && (owner_q == OWNER_INST);
            data_resp_valid <= complete && (owner_q == OWNER_DATA);

            if (complete && (owner_q == OWNER_INST)) inst_resp_rdata <= cap_data;
            if (complete && (owner_q == OWNER_DATA)) data_resp_rdata <= cap_data;
        end
    end

    // ---------------------------------------------------------------
    // Bus outputs: request only in ADDR; every field zero otherwise.
    // ---------------------------------------------------------------
    assign bus_req      = (state == ST_ADDR);
    assign bus_wr       = bus_req ? req_q.wr       : 1'b0;
    assign bus_addr     = bus_req ? req_q.paddr    : '0;
    assign bus_wstrb    = bus_req ? req_q.wstrb    : '0;
    assign bus_wdata    = bus_req ? req_q.wdata    : '0;
    assign bus_uncached = bus_req ? req_q.uncached : 1'b0;

endmodule
